// File: rtl/hilo_muldiv_sched.sv
// Off-pipeline MULT/MULTU/DIV/DIVU engine that owns every mul/div write to HI/LO.
// Stalls EX only when another HI/LO user arrives while an operation is in flight.
module hilo_muldiv_sched #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_issue_valid,
    input  logic [1:0]  i_issue_op,
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic        i_flush_ex,
    input  logic        i_cancel,
    input  logic [1:0]  i_hilo_access_ex,
    output logic        o_stall_ex,
    output logic        o_busy,
    output logic        o_hilo_we,
    output logic [63:0] o_hilo_wdata
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t       r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [31:0]  r_a, r_b;
    logic [31:0]  r_q, r_rem, r_dvs;
    logic         r_qneg, r_rneg;
    logic [31:0]  r_hi, r_lo;

    logic         w_issue;
    logic         w_sdiv;
    logic [32:0]  w_rem_sh;
    logic [33:0]  w_diff;
    logic signed [32:0] w_ma, w_mb;
    logic signed [63:0] w_prod;

    assign w_issue = (r_state == S_IDLE) && i_issue_valid && !i_flush_ex && !o_stall_ex;
    assign w_sdiv  = (i_issue_op == 2'b10);

    // Restoring step: dividend bits shift out of r_q while quotient bits shift in.
    assign w_rem_sh = {r_rem, r_q[31]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_dvs};

    // One 33x33 signed multiplier serves both forms; MULTU zero-extends.
    assign w_ma   = {~r_op[0] & r_a[31], r_a};
    assign w_mb   = {~r_op[0] & r_b[31], r_b};
    assign w_prod = w_ma * w_mb;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_next = i_issue_op[1] ? S_DIV : S_MUL;
            S_MUL:  w_next = S_DONE;
            S_DIV:  if (r_cnt == CW'(DIV_CYCLES - 1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_cancel && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_stall_ex   = o_busy && (i_issue_valid || i_hilo_access_ex != 2'b00);
        o_hilo_we    = (r_state == S_DONE) && !i_cancel;
        o_hilo_wdata = {r_hi, r_lo};
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt  <= '0;
            r_op   <= 2'b00;
            r_a    <= '0;
            r_b    <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            if (w_issue) begin
                r_op   <= i_issue_op;
                r_a    <= i_src_a;
                r_b    <= i_src_b;
                r_cnt  <= '0;
                r_rem  <= '0;
                r_q    <= (w_sdiv && i_src_a[31]) ? -i_src_a : i_src_a;
                r_dvs  <= (w_sdiv && i_src_b[31]) ? -i_src_b : i_src_b;
                r_qneg <= w_sdiv && (i_src_a[31] ^ i_src_b[31]);
                r_rneg <= w_sdiv && i_src_a[31];
            end
            if (r_state == S_DIV) begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_diff[33] ? w_rem_sh[31:0] : w_diff[31:0];
                r_q   <= {r_q[30:0], ~w_diff[33]};
            end
            // Results only change on the path to a real write, so a killed op leaves HI/LO data intact.
            if (r_state == S_MUL && !i_cancel) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
            if (r_state == S_FIX && !i_cancel) begin
                if (r_b == 32'h0) begin
                    r_hi <= r_a;
                    r_lo <= 32'hFFFF_FFFF;
                end else if (r_op == 2'b10 && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) begin
                    r_hi <= 32'h0;
                    r_lo <= 32'h8000_0000;
                end else begin
                    r_hi <= r_rneg ? -r_rem : r_rem;
                    r_lo <= r_qneg ? -r_q : r_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_sched.sv
// Directed bench for hilo_muldiv_sched: mul/div results, issue/stall timing, cancel, flush, reset.
module tb_hilo_muldiv_sched;
    logic        clk = 1'b0;
    logic        resetn;
    logic        issue_valid;
    logic [1:0]  issue_op;
    logic [31:0] src_a, src_b;
    logic        flush_ex, cancel;
    logic [1:0]  hilo_access_ex;
    logic        stall_ex, busy, hilo_we;
    logic [63:0] hilo_wdata;

    int checks = 0;
    int failures = 0;

    hilo_muldiv_sched #(.DIV_CYCLES(32)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_issue_valid(issue_valid), .i_issue_op(issue_op),
        .i_src_a(src_a), .i_src_b(src_b), .i_flush_ex(flush_ex), .i_cancel(cancel),
        .i_hilo_access_ex(hilo_access_ex), .o_stall_ex(stall_ex), .o_busy(busy),
        .o_hilo_we(hilo_we), .o_hilo_wdata(hilo_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs change and outputs settle before the check point.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present an issue in the current cycle t and advance to t+1 with issue removed.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1; issue_op = op; src_a = a; src_b = b;
        step();
        issue_valid = 1'b0;
        #1;
    endtask

    initial begin
        resetn = 1'b0; issue_valid = 1'b0; issue_op = 2'b00; src_a = '0; src_b = '0;
        flush_ex = 1'b0; cancel = 1'b0; hilo_access_ex = 2'b00;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall_ex), 64'd0);
        chk("rst_we", 64'(hilo_we), 64'd0);
        chk("rst_wdata", hilo_wdata, 64'd0);
        steps(2);
        resetn = 1'b1;
        step();

        // MULT -2 * 3
        issue(2'b00, 32'hFFFF_FFFE, 32'd3);
        chk("mult_t1_busy", 64'(busy), 64'd1);
        chk("mult_t1_we", 64'(hilo_we), 64'd0);
        step();
        chk("mult_t2_we", 64'(hilo_we), 64'd1);
        chk("mult_t2_busy", 64'(busy), 64'd1);
        chk("mult_wdata", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);
        step();
        chk("mult_t3_busy", 64'(busy), 64'd0);
        chk("mult_t3_we", 64'(hilo_we), 64'd0);

        // MULTU with a second issue held in EX during the operation
        issue(2'b01, 32'hFFFF_FFFE, 32'd3);
        issue_valid = 1'b1; issue_op = 2'b00; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
        #1;
        chk("b2b_t1_stall", 64'(stall_ex), 64'd1);
        step();
        chk("b2b_t2_stall", 64'(stall_ex), 64'd1);
        chk("multu_we", 64'(hilo_we), 64'd1);
        chk("multu_wdata", hilo_wdata, 64'h0000_0002_FFFF_FFFA);
        step();
        chk("b2b_t3_stall", 64'(stall_ex), 64'd0);
        chk("b2b_t3_busy", 64'(busy), 64'd0);
        step();
        issue_valid = 1'b0;
        #1;
        chk("b2b_issued_busy", 64'(busy), 64'd1);
        step();
        chk("mult2_we", 64'(hilo_we), 64'd1);
        chk("mult2_wdata", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFEB);
        step();

        // DIV -7 / 2
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        steps(32);
        chk("div_t33_we", 64'(hilo_we), 64'd0);
        step();
        chk("div_t34_we", 64'(hilo_we), 64'd1);
        chk("div_neg7_2", hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        chk("div_t35_busy", 64'(busy), 64'd0);

        // DIVU 5 / 0
        issue(2'b11, 32'd5, 32'd0);
        steps(33);
        chk("divu_by0_we", 64'(hilo_we), 64'd1);
        chk("divu_by0", hilo_wdata, 64'h0000_0005_FFFF_FFFF);
        step();

        // DIV overflow case
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        steps(33);
        chk("div_ovf", hilo_wdata, 64'h0000_0000_8000_0000);
        step();

        // DIV 100 / -7
        issue(2'b10, 32'd100, 32'hFFFF_FFF9);
        steps(33);
        chk("div_100_m7", hilo_wdata, 64'h0000_0002_FFFF_FFF2);
        step();

        // DIVU with HI/LO access arriving at t+5
        issue(2'b11, 32'hFFFF_FFFF, 32'h10);
        steps(3);
        chk("acc_t4_stall", 64'(stall_ex), 64'd0);
        step();
        hilo_access_ex = 2'b01;
        #1;
        for (int c = 5; c <= 34; c++) begin
            chk($sformatf("acc_t%0d_stall", c), 64'(stall_ex), 64'd1);
            if (c < 34) step();
        end
        chk("divu_acc_we", 64'(hilo_we), 64'd1);
        chk("divu_acc_wdata", hilo_wdata, 64'h0000_000F_0FFF_FFFF);
        step();
        chk("acc_t35_stall", 64'(stall_ex), 64'd0);
        hilo_access_ex = 2'b00;

        // cancel at t+10 of a DIVU
        issue(2'b11, 32'd1000, 32'd3);
        steps(9);
        cancel = 1'b1;
        #1;
        chk("cancel_t10_busy", 64'(busy), 64'd1);
        step();
        cancel = 1'b0;
        #1;
        chk("cancel_t11_busy", 64'(busy), 64'd0);
        for (int c = 0; c < 30; c++) begin
            chk("cancel_no_we", 64'(hilo_we), 64'd0);
            step();
        end
        chk("cancel_wdata_hold", hilo_wdata, 64'h0000_000F_0FFF_FFFF);

        // cancel during DONE suppresses the write
        issue(2'b00, 32'd2, 32'd3);
        step();
        cancel = 1'b1;
        #1;
        chk("cancel_done_we", 64'(hilo_we), 64'd0);
        step();
        cancel = 1'b0;
        #1;
        chk("cancel_done_idle", 64'(busy), 64'd0);

        // flushed issue is ignored
        flush_ex = 1'b1;
        issue(2'b00, 32'd9, 32'd9);
        flush_ex = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        step();
        chk("flush_no_we", 64'(hilo_we), 64'd0);

        // reset at t+12 of a DIV
        issue(2'b10, 32'd77, 32'd5);
        steps(11);
        resetn = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_we", 64'(hilo_we), 64'd0);
        chk("mrst_wdata", hilo_wdata, 64'd0);
        step();
        resetn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            chk("mrst_no_we", 64'(hilo_we), 64'd0);
            step();
        end
        issue(2'b00, 32'h10, 32'h10);
        chk("post_rst_busy", 64'(busy), 64'd1);
        step();
        chk("post_rst_we", 64'(hilo_we), 64'd1);
        chk("post_rst_wdata", hilo_wdata, 64'h0000_0000_0000_0100);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_sched.md
# hilo_muldiv_sched

Background multiply/divide scheduler that owns every multiply/divide write to the HI/LO register pair of the CPU pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage, then runs the operation off-pipeline so the issuing instruction retires normally. It stalls EX only when a later HI/LO consumer or producer (MFHI/MFLO/MTHI/MTLO, or another mul/div) arrives while an operation is in flight. It sits beside the EX-stage HI/LO forwarding logic and drives the HI/LO register write port.

## Interface
- DIV_CYCLES, 32: radix-2 restoring-divide iterations, one quotient bit per cycle; must equal operand width.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- issue_valid  in  1  EX holds a mul/div instruction
- issue_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs value (dividend / multiplicand)
- src_b  in  32  rt value (divisor / multiplier)
- flush_ex  in  1  EX instruction squashed this cycle; blocks issue
- cancel  in  1  in-flight operation's instruction squashed after leaving EX; kills the operation
- hilo_access_ex  in  2  nonzero when the EX instruction reads or writes HI/LO (MFHI/MFLO/MTHI/MTLO)
- stall_ex  out  1  hold EX and upstream this cycle
- busy  out  1  operation in flight
- hilo_we  out  1  write HI/LO at end of this cycle
- hilo_wdata  out  64  {HI, LO}

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. busy = (state != IDLE).
- Issue accepted: IDLE && issue_valid && !flush_ex && !stall_ex. Operands and op are captured at that edge.
- MUL
  - Signed (MULT) or unsigned (MULTU) 32x32 -> 64 product, registered in the MUL cycle.
  - MUL -> DONE.
- DIV setup (at the issue edge)
  - DIV: operands converted to magnitudes; quotient sign = sign(a)^sign(b); remainder sign = sign(a). DIVU: raw operands.
  - Counter cleared.
- DIV iteration: each DIV cycle shifts the partial remainder left one bit, trial-subtracts the divisor magnitude, and sets the quotient bit. After DIV_CYCLES iterations -> FIX.
- FIX
  - Signed: negate quotient and/or remainder per the captured signs.
  - Divide by zero (either sign): LO = 0xFFFFFFFF, HI = src_a as captured; no sign fixup.
  - 0x80000000 / -1: LO = 0x80000000, HI = 0.
  - FIX -> DONE.
- DONE: hilo_wdata = {remainder, quotient} for div, {prod[63:32], prod[31:0]} for mul; hilo_we = !cancel; next state IDLE.
- stall_ex = busy && (issue_valid || hilo_access_ex != 0). Stall therefore covers the DONE cycle, so an MFHI/MFLO in EX always reads the updated register and never a stale one.
- cancel
  - Any non-IDLE state: returns to IDLE next edge; no hilo_we pulse.
  - In DONE: suppresses the write combinationally.
  - In IDLE: ignored.
- flush_ex never affects an in-flight operation.
- Reset: state IDLE, counter 0, all captured/result registers 0. Outputs: stall_ex 0, busy 0, hilo_we 0, hilo_wdata 0. Reset mid-operation discards it with no write.

## Timing
- Issue at cycle t (edge ending t).
- MUL: MUL in t+1; DONE, hilo_we=1 in t+2; IDLE in t+3.
- DIV/DIVU: DIV in t+1..t+DIV_CYCLES; FIX in t+DIV_CYCLES+1; DONE, hilo_we=1 in t+DIV_CYCLES+2 (t+34 by default); IDLE in t+35.
- Minimum latency of 2 cycles guarantees that an older MTHI/MTLO in MEM/WB at issue writes HI/LO before this block does, preserving program order.
- A stalled HI/LO access or new issue proceeds in the first IDLE cycle. Back-to-back issue is possible at t+3 (mul) or t+35 (div).
- hilo_wdata is valid whenever hilo_we=1 and holds its value until the next DONE.
- stall_ex, hilo_we: combinational from state and inputs. No other outputs depend combinationally on inputs.

## Test plan
- MULT a=0xFFFFFFFE, b=3 at t -> hilo_we=1 only in t+2, hilo_wdata=0xFFFFFFFF_FFFFFFFA; busy t+1..t+2.
- MULTU a=0xFFFFFFFE, b=3 -> hilo_wdata=0x00000002_FFFFFFFA at t+2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> at t+34 LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU issued at t, hilo_access_ex=01 from t+5 -> stall_ex=1 in t+5..t+34, 0 at t+35; second issue_valid during MUL stalls until t+3.
- cancel pulsed at t+10 of a DIVU -> IDLE at t+11, no hilo_we; issue with flush_ex=1 -> busy stays 0.
- resetn low at t+12 of a DIV -> all outputs 0 immediately, IDLE; no write after release; a fresh MULT issues normally.
